// File: rtl/auth_code_setter.sv
// Enrollment controller for the combination-lock authenticator.
// It owns the secret code. A new code must be entered twice before it is
// committed, and the current code must be proven first when one exists.
// Repeated mismatches put the block into a timed lockout.
module auth_code_setter #(
    parameter int CODE_W      = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYC    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_req,
    input  logic              cancel,
    input  logic              enter,
    input  logic [CODE_W-1:0] code_in,
    output logic [CODE_W-1:0] stored_code,
    output logic              code_valid,
    output logic              busy,
    output logic              locked,
    output logic              set_done,
    output logic              set_fail
);
    localparam int MAX_TL = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
    localparam int MAXV   = (MAX_TL > MAX_FAIL) ? MAX_TL : MAX_FAIL;
    localparam int CNT_W  = $clog2(MAXV + 1);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] FAIL_MAX  = CNT_W'(MAX_FAIL);

    typedef enum logic [2:0] {
        IDLE, VERIFY_OLD, ENTER_NEW, CONFIRM_NEW, LOCKOUT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  timer, fail_cnt, fail_nxt, fail_inc;
    logic [CODE_W-1:0] new_reg, new_nxt;
    logic              enter_q, ent, active;
    logic              commit, fail_p, mismatch;

    // A held button yields exactly one entry.
    assign ent      = enter & ~enter_q;
    assign active   = (state == VERIFY_OLD) || (state == ENTER_NEW) || (state == CONFIRM_NEW);
    assign fail_inc = (fail_cnt == '1) ? fail_cnt : fail_cnt + 1'b1;

    // Next state and the events of the current cycle.
    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        new_nxt   = new_reg;
        commit    = 1'b0;
        fail_p    = 1'b0;
        mismatch  = 1'b0;
        case (state)
            IDLE: begin
                if (set_req) state_nxt = code_valid ? VERIFY_OLD : ENTER_NEW;
            end
            VERIFY_OLD, ENTER_NEW, CONFIRM_NEW: begin
                // cancel outranks both an entry and a timeout in the same cycle
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (ent) begin
                    case (state)
                        VERIFY_OLD: begin
                            if (code_in == stored_code) state_nxt = ENTER_NEW;
                            else                        mismatch  = 1'b1;
                        end
                        ENTER_NEW: begin
                            new_nxt   = code_in;
                            state_nxt = CONFIRM_NEW;
                        end
                        default: begin
                            if (code_in == new_reg) begin
                                commit    = 1'b1;
                                fail_nxt  = '0;
                                state_nxt = IDLE;
                            end else begin
                                mismatch = 1'b1;
                            end
                        end
                    endcase
                end else if (timer >= TMO_LAST) begin
                    // a timeout aborts but does not count toward lockout
                    fail_p    = 1'b1;
                    state_nxt = IDLE;
                end
                if (mismatch) begin
                    fail_p = 1'b1;
                    if (fail_inc == FAIL_MAX) begin
                        state_nxt = LOCKOUT;
                        fail_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                        fail_nxt  = fail_inc;
                    end
                end
            end
            LOCKOUT: begin
                if (timer >= LOCK_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and entry edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            fail_cnt <= '0;
            new_reg  <= '0;
            enter_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_nxt;
            new_reg  <= new_nxt;
            enter_q  <= enter;
            // During lockout, entries are ignored and do not stretch the lockout.
            if (state_nxt != state || state == IDLE || (ent && active)) timer <= '0;
            else if (timer != '1)                                         timer <= timer + 1'b1;
        end
    end

    // Registered outputs; pulses line up with the state they lead into.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stored_code <= '0;
            code_valid  <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            set_done    <= 1'b0;
            set_fail    <= 1'b0;
        end else begin
            busy     <= (state_nxt != IDLE);
            locked   <= (state_nxt == LOCKOUT);
            set_done <= commit;
            set_fail <= fail_p;
            if (commit) begin
                stored_code <= new_reg;
                code_valid  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_auth_code_setter.sv
// Directed bench for auth_code_setter.
// Inputs change on the falling edge, and outputs are observed there.
// Observed vector: {busy, locked, set_done, set_fail, code_valid, stored_code[3:0]}.
module tb_auth_code_setter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_req = 1'b0, cancel = 1'b0, enter = 1'b0;
    logic [3:0] code_in = 4'b0000;
    logic [3:0] stored_code;
    logic       code_valid, busy, locked, set_done, set_fail;

    int checks = 0;
    int errors = 0;
    logic [8:0] obs;

    auth_code_setter #(.CODE_W(4), .TIMEOUT_CYC(16), .MAX_FAIL(3), .LOCK_CYC(8)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .cancel(cancel), .enter(enter),
        .code_in(code_in), .stored_code(stored_code), .code_valid(code_valid),
        .busy(busy), .locked(locked), .set_done(set_done), .set_fail(set_fail)
    );

    always #5 clk = ~clk;

    assign obs = {busy, locked, set_done, set_fail, code_valid, stored_code};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request; on return the state change is visible.
    task automatic req();
        set_req = 1'b1;
        tick(1);
        set_req = 1'b0;
    endtask

    // One entry. Enter is held low for one edge, then high for one edge.
    // On return, any pulse from this entry is visible.
    task automatic press(input logic [3:0] c);
        enter = 1'b0;
        code_in = c;
        tick(1);
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        if (obs !== 9'b0_0_0_0_0_0000) begin errors++; $display("FAIL reset_hold got %b exp %b", obs, 9'b0); end
        checks++;
        rst = 1'b0;
        tick(1);
        if (obs !== 9'b0_0_0_0_0_0000) begin errors++; $display("FAIL reset_release got %b exp %b", obs, 9'b0); end
        checks++;
    endtask

    task automatic test_first_enroll();
        req();
        if (obs !== 9'b1_0_0_0_0_0000) begin errors++; $display("FAIL enroll_req got %b exp %b", obs, 9'b1_0_0_0_0_0000); end
        checks++;
        press(4'b1011);
        if (obs !== 9'b1_0_0_0_0_0000) begin errors++; $display("FAIL enroll_new got %b exp %b", obs, 9'b1_0_0_0_0_0000); end
        checks++;
        press(4'b1011);
        if (obs !== 9'b0_0_1_0_1_1011) begin errors++; $display("FAIL enroll_commit got %b exp %b", obs, 9'b0_0_1_0_1_1011); end
        checks++;
        tick(1);
        if (obs !== 9'b0_0_0_0_1_1011) begin errors++; $display("FAIL enroll_pulse_end got %b exp %b", obs, 9'b0_0_0_0_1_1011); end
        checks++;
    endtask

    task automatic test_reenroll();
        // A wrong old code is a mismatch. The stored code is kept.
        req();
        press(4'b0000);
        if (obs !== 9'b0_0_0_1_1_1011) begin errors++; $display("FAIL wrong_old got %b exp %b", obs, 9'b0_0_0_1_1_1011); end
        checks++;
        req();
        if (obs !== 9'b1_0_0_0_1_1011) begin errors++; $display("FAIL reenroll_req got %b exp %b", obs, 9'b1_0_0_0_1_1011); end
        checks++;
        press(4'b1011);
        if (obs !== 9'b1_0_0_0_1_1011) begin errors++; $display("FAIL old_ok got %b exp %b", obs, 9'b1_0_0_0_1_1011); end
        checks++;
        press(4'b0110);
        press(4'b0110);
        if (obs !== 9'b0_0_1_0_1_0110) begin errors++; $display("FAIL reenroll_commit got %b exp %b", obs, 9'b0_0_1_0_1_0110); end
        checks++;
    endtask

    // The commit above cleared the earlier miss, so lockout must wait for the third miss.
    task automatic test_lockout();
        for (int k = 1; k <= 3; k++) begin
            req();
            press(4'b0110);
            press(4'b0011);
            press(4'b0010);
            if (k < 3) begin
                if (obs !== 9'b0_0_0_1_1_0110) begin errors++; $display("FAIL confirm_miss%0d got %b exp %b", k, obs, 9'b0_0_0_1_1_0110); end
                checks++;
            end else begin
                if (obs !== 9'b1_1_0_1_1_0110) begin errors++; $display("FAIL lock_enter got %b exp %b", obs, 9'b1_1_0_1_1_0110); end
                checks++;
            end
        end
        // Seven more locked cycles, with set_req and an entry attempt that must be ignored.
        set_req = 1'b1;
        for (int i = 1; i < 8; i++) begin
            enter = (i == 3);
            code_in = 4'b0110;
            tick(1);
            if (obs !== 9'b1_1_0_0_1_0110) begin errors++; $display("FAIL lock_cycle%0d got %b exp %b", i, obs, 9'b1_1_0_0_1_0110); end
            checks++;
        end
        set_req = 1'b0;
        enter = 1'b0;
        tick(1);
        if (obs !== 9'b0_0_0_0_1_0110) begin errors++; $display("FAIL lock_exit got %b exp %b", obs, 9'b0_0_0_0_1_0110); end
        checks++;
    endtask

    task automatic test_timeout();
        req();
        tick(15);
        if (obs !== 9'b1_0_0_0_1_0110) begin errors++; $display("FAIL tmo_before got %b exp %b", obs, 9'b1_0_0_0_1_0110); end
        checks++;
        tick(1);
        if (obs !== 9'b0_0_0_1_1_0110) begin errors++; $display("FAIL tmo_fire got %b exp %b", obs, 9'b0_0_0_1_1_0110); end
        checks++;
    endtask

    task automatic test_edge_priority();
        // Holding enter high counts as one entry, so the later code changes are not entries.
        req();
        code_in = 4'b0110;
        enter = 1'b1;
        tick(1);
        code_in = 4'b1111;
        tick(4);
        enter = 1'b0;
        if (obs !== 9'b1_0_0_0_1_0110) begin errors++; $display("FAIL held_enter got %b exp %b", obs, 9'b1_0_0_0_1_0110); end
        checks++;
        press(4'b0101);
        // Cancel with a matching confirm entry must return to IDLE with no pulse.
        tick(1);
        code_in = 4'b0101;
        enter = 1'b1;
        cancel = 1'b1;
        tick(1);
        enter = 1'b0;
        cancel = 1'b0;
        if (obs !== 9'b0_0_0_0_1_0110) begin errors++; $display("FAIL cancel_enter got %b exp %b", obs, 9'b0_0_0_0_1_0110); end
        checks++;
        // An entry made together with set_req in IDLE must not be consumed.
        tick(1);
        code_in = 4'b0000;
        set_req = 1'b1;
        enter = 1'b1;
        tick(1);
        set_req = 1'b0;
        tick(1);
        enter = 1'b0;
        if (obs !== 9'b1_0_0_0_1_0110) begin errors++; $display("FAIL req_enter got %b exp %b", obs, 9'b1_0_0_0_1_0110); end
        checks++;
        press(4'b0110);
        press(4'b1001);
        press(4'b1001);
        if (obs !== 9'b0_0_1_0_1_1001) begin errors++; $display("FAIL back_to_back_commit got %b exp %b", obs, 9'b0_0_1_0_1_1001); end
        checks++;
    endtask

    task automatic test_async_reset();
        req();
        press(4'b1001);
        press(4'b0001);
        if (obs !== 9'b1_0_0_0_1_1001) begin errors++; $display("FAIL pre_rst got %b exp %b", obs, 9'b1_0_0_0_1_1001); end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (obs !== 9'b0) begin errors++; $display("FAIL async_rst got %b exp %b", obs, 9'b0); end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        if (obs !== 9'b0) begin errors++; $display("FAIL post_rst got %b exp %b", obs, 9'b0); end
        checks++;
        // After reset, no code exists, so the old-code step is skipped.
        req();
        press(4'b0111);
        press(4'b0111);
        if (obs !== 9'b0_0_1_0_1_0111) begin errors++; $display("FAIL post_rst_enroll got %b exp %b", obs, 9'b0_0_1_0_1_0111); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_first_enroll();
        test_reenroll();
        test_lockout();
        test_timeout();
        test_edge_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
